univ_register: RTL

Parametrised universal register: the next generation of the lab's 4-bit D flip-flop bank. It adds a clock enable, a mode select (hold, parallel load, shift, rotate, count up/down), a serial input and output, and a terminal-count flag. It serves as the generic storage/shift/count element for later lab exercises and is instantiated directly by their testbenches.

---
 rtl/univ_register_pkg.sv | 27 ++
 rtl/univ_register_next.sv | 58 +++++
 rtl/univ_register.sv | 88 ++++++++
 3 files changed

// File: rtl/univ_register_pkg.sv
// Shared definitions for the universal register: mode encodings and a small
// mode-classification helper used by the next-state logic.
package univ_register_pkg;

  // Operation select encodings, used by the RTL, benches and instantiating code.
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_UP   = 3'b110;
  localparam logic [2:0] MODE_DOWN = 3'b111;

  typedef logic [2:0] mode_t;

  // True for the four modes that move a bit out through sout.
  function automatic logic mode_moves_sout(input mode_t mode);
    logic r;
    case (mode)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/univ_register_next.sv
// Purely combinational next-state logic for univ_register. Produces the
// candidate register value, the bit leaving the register and a strobe that
// says whether sout should take that bit on this edge.
module univ_register_next
  import univ_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_i,
  input  logic [2:0]       mode_i,
  output logic [WIDTH-1:0] next_y_o,
  output logic             next_sout_o,
  output logic             sout_upd_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Select the next register value and outgoing bit for the requested mode.
  always_comb begin
    next_y_o    = y_i;
    next_sout_o = 1'b0;
    case (mode_i)
      MODE_HOLD: next_y_o = y_i;
      MODE_LOAD: next_y_o = d_i;
      MODE_SHL: begin
        next_y_o    = {y_i[WIDTH-2:0], sin_i};
        next_sout_o = y_i[WIDTH-1];
      end
      MODE_SHR: begin
        next_y_o    = {sin_i, y_i[WIDTH-1:1]};
        next_sout_o = y_i[0];
      end
      MODE_ROL: begin
        next_y_o    = {y_i[WIDTH-2:0], y_i[WIDTH-1]};
        next_sout_o = y_i[WIDTH-1];
      end
      MODE_ROR: begin
        next_y_o    = {y_i[0], y_i[WIDTH-1:1]};
        next_sout_o = y_i[0];
      end
      // Plain modulo arithmetic: the carry/borrow out is simply dropped.
      MODE_UP:   next_y_o = y_i + ONE;
      MODE_DOWN: next_y_o = y_i - ONE;
      default: begin
        next_y_o    = y_i;
        next_sout_o = 1'b0;
      end
    endcase
  end

  // sout only changes on shift and rotate edges; it keeps its value otherwise.
  always_comb begin
    sout_upd_o = mode_moves_sout(mode_i);
  end

endmodule

// File: rtl/univ_register.sv
// Parametrised universal register: hold, parallel load, shift, rotate and
// up/down count with clock enable, serial in/out and a terminal-count flag.
// tc is combinational so a cascaded instance can use it directly as its en.
module univ_register
  import univ_register_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin,
  output logic [WIDTH-1:0] Y,
  output logic             sout,
  output logic             tc
);

  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;
  logic             sout_q;
  logic             sout_d;
  logic [WIDTH-1:0] next_y_s;
  logic             next_sout_s;
  logic             sout_upd_s;
  logic             tc_s;

  univ_register_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .y_i        (y_q),
    .d_i        (D),
    .sin_i      (sin),
    .mode_i     (mode),
    .next_y_o   (next_y_s),
    .next_sout_o(next_sout_s),
    .sout_upd_o (sout_upd_s)
  );

  // Clock-enable gating: with en low every mode degenerates to hold.
  always_comb begin
    y_d    = y_q;
    sout_d = sout_q;
    if (en) begin
      y_d = next_y_s;
      if (sout_upd_s) begin
        sout_d = next_sout_s;
      end else begin
        sout_d = sout_q;
      end
    end else begin
      y_d    = y_q;
      sout_d = sout_q;
    end
  end

  // State flops; the asynchronous active-low reset overrides any edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q    <= RESET_VAL;
      sout_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      sout_q <= sout_d;
    end
  end

  // Terminal count: the next enabled count edge would wrap the register.
  always_comb begin
    tc_s = 1'b0;
    if (en) begin
      case (mode)
        MODE_UP:   tc_s = &y_q;
        MODE_DOWN: tc_s = ~|y_q;
        default:   tc_s = 1'b0;
      endcase
    end else begin
      tc_s = 1'b0;
    end
  end

  assign Y    = y_q;
  assign sout = sout_q;
  assign tc   = tc_s;

endmodule
